// File: rtl/chk_pkg.sv
// Shared types and constants for the counting-pattern checker: FSM state codes,
// uo_out view selects and the status byte layout.
package chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  localparam logic [1:0] VIEW_STATUS = 2'd0;
  localparam logic [1:0] VIEW_ERR    = 2'd1;
  localparam logic [1:0] VIEW_SAMPLE = 2'd2;
  localparam logic [1:0] VIEW_GOOD   = 2'd3;

  localparam int STAT_LOCKED    = 7;
  localparam int STAT_EVER      = 6;
  localparam int STAT_ERR_SAT   = 5;
  localparam int STAT_STATE_LSB = 3;
  localparam int STAT_MISS_LSB  = 0;

  function automatic logic [7:0] pack_status(input logic       locked,
                                             input logic       ever_locked,
                                             input logic       err_sat,
                                             input logic [1:0] state,
                                             input logic [2:0] miss);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_LOCKED]             = locked;
    s[STAT_EVER]               = ever_locked;
    s[STAT_ERR_SAT]            = err_sat;
    s[STAT_STATE_LSB +: 2]     = state;
    s[STAT_MISS_LSB +: 3]      = miss;
    return s;
  endfunction

endpackage

// File: rtl/chk_seq_tracker.sv
// Lock-acquisition FSM for the +1 counting pattern: tracks the previous sample,
// the run of good increments while acquiring and the run of misses while locked.
//
// state  | meaning
// IDLE   | checking disabled, prev follows the sample
// ACQ    | counting consecutive good increments towards lock
// LOCKED | locked; matches/mismatches feed the counters
module chk_seq_tracker
  import chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] sample,
  output chk_state_t state,
  output logic [2:0] miss_view,
  output logic       locked,
  output logic       good_stb,
  output logic       err_stb,
  output logic       lock_stb
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] MISS_LAST = 4'(UNLOCK_CNT - 1);

  logic [7:0] prev;
  logic [3:0] run;
  logic [3:0] miss;
  logic       match;

  // 8-bit add wraps naturally, so prev=FF expects 00
  assign match     = (sample == 8'(prev + 8'd1));
  assign good_stb  = en && (state == ST_LOCKED) && match;
  assign err_stb   = en && (state == ST_LOCKED) && !match;
  assign lock_stb  = en && (state == ST_ACQ) && match && (run == LOCK_LAST);
  assign miss_view = miss[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      prev   <= 8'h00;
      run    <= 4'd0;
      miss   <= 4'd0;
      locked <= 1'b0;
    end else begin
      prev <= sample;
      if (!en) begin
        state  <= ST_IDLE;
        run    <= 4'd0;
        miss   <= 4'd0;
        locked <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ACQ;
            run   <= 4'd0;
            miss  <= 4'd0;
          end
          ST_ACQ: begin
            if (match) begin
              if (run == LOCK_LAST) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                run    <= 4'd0;
                miss   <= 4'd0;
              end else begin
                run <= run + 4'd1;
              end
            end else begin
              run <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              miss <= 4'd0;
            end else if (miss == MISS_LAST) begin
              state  <= ST_ACQ;
              locked <= 1'b0;
              run    <= 4'd0;
              miss   <= 4'd0;
            end else begin
              miss <= miss + 4'd1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tt_um_cnt_pattern_checker.sv
// Receive-side checker for the free-running 8-bit counter source on uio_in.
// Define CHK_INPUT_SYNC_EN to put a 2-flop synchronizer ahead of the sample register.
module tt_um_cnt_pattern_checker
  import chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int          GOOD_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  logic              rst_n_i;
  logic [7:0]        pat_in;
  logic [7:0]        sample;
  logic [7:0]        err_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              err_sat;
  logic              ever_locked;
  chk_state_t        state;
  logic [2:0]        miss_view;
  logic              locked;
  logic              good_stb;
  logic              err_stb;
  logic              lock_stb;
  logic              en;
  logic              clr;
  logic              unused_ok;

  assign en        = ui_in[0];
  assign clr       = ui_in[3];
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, ena, ui_in[7:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_n_i <= 1'b0;
    else        rst_n_i <= 1'b1;
  end

`ifdef CHK_INPUT_SYNC_EN
  logic [7:0] sync_q1;
  logic [7:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q1 <= 8'h00;
      sync_q2 <= 8'h00;
    end else begin
      sync_q1 <= uio_in;
      sync_q2 <= sync_q1;
    end
  end

  assign pat_in = sync_q2;
`else
  assign pat_in = uio_in;
`endif

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) sample <= 8'h00;
    else          sample <= pat_in;
  end

  chk_seq_tracker #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n_i),
    .en       (en),
    .sample   (sample),
    .state    (state),
    .miss_view(miss_view),
    .locked   (locked),
    .good_stb (good_stb),
    .err_stb  (err_stb),
    .lock_stb (lock_stb)
  );

  // clear wins over a same-cycle increment or lock event
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt     <= 8'h00;
      good_cnt    <= '0;
      err_sat     <= 1'b0;
      ever_locked <= 1'b0;
    end else if (clr) begin
      err_cnt     <= 8'h00;
      good_cnt    <= '0;
      err_sat     <= 1'b0;
      ever_locked <= 1'b0;
    end else begin
      if (lock_stb) ever_locked <= 1'b1;
      if (good_stb && (good_cnt != {GOOD_W{1'b1}})) good_cnt <= good_cnt + 1'b1;
      if (err_stb) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (err_cnt >= 8'hFE) err_sat <= 1'b1;
      end
    end
  end

  always_comb begin
    uo_out = 8'h00;
    if (rst_n_i) begin
      case (ui_in[2:1])
        VIEW_STATUS: uo_out = pack_status(locked, ever_locked, err_sat, state, miss_view);
        VIEW_ERR:    uo_out = err_cnt;
        VIEW_SAMPLE: uo_out = sample;
        VIEW_GOOD:   uo_out = good_cnt[GOOD_W-1 -: 8];
        default:     uo_out = 8'h00;
      endcase
    end
  end

endmodule
